// File: rtl/stopwatch_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_bcd
//  Brief    : Centisecond MM:SS.CC stopwatch with lap freeze, BCD display word.
//  Revision : 1.0 - initial release
// ============================================================================
module stopwatch_bcd #(
    parameter int CS_DIV = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_ss,
    input  logic        btn_lr,
    output logic [31:0] disp,
    output logic        running,
    output logic        frozen
);

    localparam int             c_PW   = $clog2(CS_DIV);
    localparam logic [c_PW-1:0] c_PMAX = c_PW'(CS_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_LAP   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic              r_ss_d;
    logic              r_lr_d;
    logic [c_PW-1:0]   r_presc;
    logic [23:0]       r_digits;
    logic [23:0]       r_frz;
    logic [7:0]        r_lap;

    logic              w_ss_edge;
    logic              w_lr_edge;
    logic              w_capture;
    logic              w_clear;
    logic              w_count;
    logic              w_tick;
    logic [23:0]       w_digits_nx;
    logic [7:0]        w_lap_nx;

    // Start/stop has priority when both buttons rise together.
    assign w_ss_edge = btn_ss & ~r_ss_d;
    assign w_lr_edge = btn_lr & ~r_lr_d & ~w_ss_edge;

    assign w_count = (r_state == S_RUN) || (r_state == S_LAP);
    assign w_tick  = w_count && (r_presc == c_PMAX);

    always_comb begin
        w_state_nx = r_state;
        w_capture  = 1'b0;
        w_clear    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ss_edge) w_state_nx = S_RUN;
            end
            S_RUN: begin
                if (w_ss_edge) begin
                    w_state_nx = S_PAUSE;
                end else if (w_lr_edge) begin
                    w_state_nx = S_LAP;
                    w_capture  = 1'b1;
                end
            end
            S_LAP: begin
                if (w_ss_edge)      w_state_nx = S_PAUSE;
                else if (w_lr_edge) w_state_nx = S_RUN;
            end
            S_PAUSE: begin
                if (w_ss_edge) begin
                    w_state_nx = S_RUN;
                end else if (w_lr_edge) begin
                    w_state_nx = S_IDLE;
                    w_clear    = 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Ripple the tick through the six digits; tens of seconds/minutes wrap at 5.
    always_comb begin
        logic w_carry;
        w_digits_nx = r_digits;
        w_carry     = w_tick;
        for (int i = 0; i < 6; i++) begin
            if (w_carry) begin
                if (r_digits[i*4 +: 4] == (((i == 3) || (i == 5)) ? 4'd5 : 4'd9)) begin
                    w_digits_nx[i*4 +: 4] = 4'd0;
                end else begin
                    w_digits_nx[i*4 +: 4] = r_digits[i*4 +: 4] + 4'd1;
                    w_carry               = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_lap_nx = r_lap;
        if (r_lap[3:0] == 4'd9) begin
            w_lap_nx[3:0] = 4'd0;
            w_lap_nx[7:4] = (r_lap[7:4] == 4'd9) ? 4'd0 : r_lap[7:4] + 4'd1;
        end else begin
            w_lap_nx[3:0] = r_lap[3:0] + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ss_d   <= 1'b1;
            r_lr_d   <= 1'b1;
            r_presc  <= '0;
            r_digits <= '0;
            r_frz    <= '0;
            r_lap    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ss_d  <= btn_ss;
            r_lr_d  <= btn_lr;
            if (w_clear) begin
                r_presc  <= '0;
                r_digits <= '0;
                r_lap    <= '0;
            end else begin
                if (w_count) r_presc <= w_tick ? '0 : r_presc + c_PW'(1);
                r_digits <= w_digits_nx;
                // Freeze the post-tick value so the lap shows what disp shows now.
                if (w_capture) begin
                    r_lap <= w_lap_nx;
                    r_frz <= w_digits_nx;
                end
            end
        end
    end

    assign running = (r_state == S_RUN) || (r_state == S_LAP);
    assign frozen  = (r_state == S_LAP);
    assign disp    = {r_lap, (r_state == S_LAP) ? r_frz : r_digits};

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stopwatch_bcd
//  Brief    : Directed self-checking bench for stopwatch_bcd (CS_DIV = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_bcd;

    localparam int CS_DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_ss;
    logic        btn_lr;
    logic [31:0] disp;
    logic        running;
    logic        frozen;
    logic [7:0]  lap_field;

    int vecs = 0;
    int miss = 0;

    stopwatch_bcd #(.CS_DIV(CS_DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_ss  (btn_ss),
        .btn_lr  (btn_lr),
        .disp    (disp),
        .running (running),
        .frozen  (frozen)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_ss();
        btn_ss = 1'b1;
        step(1);
        btn_ss = 1'b0;
    endtask

    task automatic press_lr();
        btn_lr = 1'b1;
        step(1);
        btn_lr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        vecs++; if (disp !== 32'h0) begin miss++; $display("FAIL reset_disp got %h want %h", disp, 32'h0); end
        vecs++; if (running !== 1'b0) begin miss++; $display("FAIL reset_running got %b want 0", running); end
        vecs++; if (frozen !== 1'b0) begin miss++; $display("FAIL reset_frozen got %b want 0", frozen); end
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_run();
        press_ss();
        vecs++; if (running !== 1'b1) begin miss++; $display("FAIL run_start got %b want 1", running); end
        step(4);
        vecs++; if (disp !== 32'h0000_0001) begin miss++; $display("FAIL run_first_tick got %h want %h", disp, 32'h0000_0001); end
        step(396);
        vecs++; if (disp !== 32'h0000_0100) begin miss++; $display("FAIL run_1s got %h want %h", disp, 32'h0000_0100); end
    endtask

    task automatic test_wrap();
        force dut.r_digits = 24'h595999;
        step(1);
        release dut.r_digits;
        vecs++; if (disp !== 32'h0059_5999) begin miss++; $display("FAIL wrap_load got %h want %h", disp, 32'h0059_5999); end
        step(3);
        vecs++; if (disp !== 32'h0000_0000) begin miss++; $display("FAIL wrap_disp got %h want %h", disp, 32'h0); end
        vecs++; if (running !== 1'b1) begin miss++; $display("FAIL wrap_running got %b want 1", running); end
    endtask

    task automatic test_lap();
        step(147);
        press_lr();
        vecs++; if (frozen !== 1'b1) begin miss++; $display("FAIL lap_frozen got %b want 1", frozen); end
        vecs++; if (disp !== 32'h0100_0037) begin miss++; $display("FAIL lap_capture got %h want %h", disp, 32'h0100_0037); end
        step(20);
        vecs++; if (disp !== 32'h0100_0037) begin miss++; $display("FAIL lap_hold got %h want %h", disp, 32'h0100_0037); end
        press_lr();
        vecs++; if (disp !== 32'h0100_0042) begin miss++; $display("FAIL lap_live got %h want %h", disp, 32'h0100_0042); end
        vecs++; if (frozen !== 1'b0) begin miss++; $display("FAIL lap_release got %b want 0", frozen); end
    endtask

    task automatic test_pause();
        press_ss();
        vecs++; if (running !== 1'b0) begin miss++; $display("FAIL pause_running got %b want 0", running); end
        vecs++; if (disp !== 32'h0100_0042) begin miss++; $display("FAIL pause_enter got %h want %h", disp, 32'h0100_0042); end
        step(50);
        vecs++; if (disp !== 32'h0100_0042) begin miss++; $display("FAIL pause_hold got %h want %h", disp, 32'h0100_0042); end
        press_ss();
        vecs++; if (running !== 1'b1) begin miss++; $display("FAIL resume_running got %b want 1", running); end
        step(1);
        vecs++; if (disp !== 32'h0100_0042) begin miss++; $display("FAIL resume_early got %h want %h", disp, 32'h0100_0042); end
        step(1);
        vecs++; if (disp !== 32'h0100_0043) begin miss++; $display("FAIL resume_tick got %h want %h", disp, 32'h0100_0043); end
    endtask

    task automatic test_simultaneous();
        btn_ss = 1'b1;
        btn_lr = 1'b1;
        step(1);
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        vecs++; if (running !== 1'b0) begin miss++; $display("FAIL simul_running got %b want 0", running); end
        vecs++; if (frozen !== 1'b0) begin miss++; $display("FAIL simul_frozen got %b want 0", frozen); end
        vecs++; if (disp !== 32'h0100_0043) begin miss++; $display("FAIL simul_disp got %h want %h", disp, 32'h0100_0043); end
        step(1);
        press_lr();
        vecs++; if (disp !== 32'h0) begin miss++; $display("FAIL pause_clear got %h want %h", disp, 32'h0); end
        vecs++; if (running !== 1'b0) begin miss++; $display("FAIL pause_idle got %b want 0", running); end
    endtask

    task automatic test_reset_mid();
        press_ss();
        step(1);
        for (int i = 0; i < 13; i++) begin
            press_lr();
            step(1);
        end
        lap_field = disp[31:24];
        vecs++; if (frozen !== 1'b1) begin miss++; $display("FAIL mid_in_lap got %b want 1", frozen); end
        vecs++; if (lap_field !== 8'h07) begin miss++; $display("FAIL mid_lap07 got %h want %h", lap_field, 8'h07); end
        btn_ss = 1'b1;
        rst_n  = 1'b0;
        step(1);
        vecs++; if (disp !== 32'h0) begin miss++; $display("FAIL mid_disp got %h want %h", disp, 32'h0); end
        vecs++; if (frozen !== 1'b0) begin miss++; $display("FAIL mid_frozen got %b want 0", frozen); end
        vecs++; if (running !== 1'b0) begin miss++; $display("FAIL mid_running got %b want 0", running); end
        rst_n = 1'b1;
        step(3);
        vecs++; if (running !== 1'b0) begin miss++; $display("FAIL held_btn_start got %b want 0", running); end
        btn_ss = 1'b0;
        step(1);
        press_ss();
        vecs++; if (running !== 1'b1) begin miss++; $display("FAIL restart got %b want 1", running); end
    endtask

    task automatic test_lap_wrap();
        step(1);
        for (int i = 0; i < 197; i++) begin
            press_lr();
            step(1);
        end
        lap_field = disp[31:24];
        vecs++; if (lap_field !== 8'h99) begin miss++; $display("FAIL lap99 got %h want %h", lap_field, 8'h99); end
        for (int i = 0; i < 2; i++) begin
            press_lr();
            step(1);
        end
        lap_field = disp[31:24];
        vecs++; if (lap_field !== 8'h00) begin miss++; $display("FAIL lap_wrap got %h want %h", lap_field, 8'h00); end
        vecs++; if (frozen !== 1'b1) begin miss++; $display("FAIL lap_wrap_frozen got %b want 1", frozen); end
    endtask

    initial begin
        rst_n  = 1'b0;
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        lap_field = 8'h0;
        test_reset();
        test_run();
        test_wrap();
        test_lap();
        test_pause();
        test_simultaneous();
        test_reset_mid();
        test_lap_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
`default_nettype wire
